demux1to4_stream: RTL
=====================

# demux1to4_stream

Registered 1-to-4 stream demultiplexer: routes each word accepted on a single valid/ready input to one of four output lanes selected by `sel`. It is the inverse of the team's 4-to-1 lane mux and uses the same `sel` to lane mapping, so a demux followed by the mux with the same `sel` returns the original word. Each lane has a one-entry output register with independent backpressure and a wrapping delivered-word counter for link debug.

## Interface
- `W`, 4, data width of the input and of every lane.
- `CNT_W`, 8, width of each per-lane delivered-word counter.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  W  input word.
- `in_sel`  in  2  lane select, qualified by `in_valid`.
- `in_valid`  in  1  input word and select are valid.
- `in_ready`  out  1  block accepts the input word this cycle.
- `a_data`, `b_data`, `c_data`, `d_data`  out  W each  lane data.
- `a_valid`, `b_valid`, `c_valid`, `d_valid`  out  1 each  lane holds a word.
- `a_ready`, `b_ready`, `c_ready`, `d_ready`  in  1 each  downstream accepts the lane word.
- `a_cnt`, `b_cnt`, `c_cnt`, `d_cnt`  out  CNT_W each  words delivered on the lane, modulo 2^CNT_W.

## Operation
- **Lane mapping** (identical to the mux):
  - `in_sel`=00 → lane b
  - 01 → lane a
  - 10 → lane c
  - 11 → lane d
- **Lane slot:** each lane has one register slot holding `{data, valid}`. A slot is free when its valid is 0, or when its valid is 1 and its ready is 1 in the same cycle (drain and refill in one cycle).
- **Input ready:** `in_ready` = slot of `lane(in_sel)` is free. It is combinational from `in_sel`, the selected lane's valid and the selected lane's ready. It is independent of `in_valid`.
- **Accept:** occurs when `in_valid & in_ready`. On the next edge the selected slot loads `in_data` and sets valid to 1. No other slot is modified.
- **Source hold rule:** while `in_valid`=1 and `in_ready`=0, the source holds `in_data` and `in_sel` stable. The block does not check this.
- **Output hold rule:** while `x_valid`=1 and `x_ready`=0, `x_data` and `x_valid` stay unchanged.
- **Drain:** when `x_valid & x_ready` and there is no refill, valid clears on the next edge. Data keeps its last value; it is don't-care but must not be X.
- **Counters:** `x_cnt` increments by 1 on every output handshake `x_valid & x_ready`. It wraps from 2^CNT_W−1 to 0. It is not saturating and has no clear other than `rst`.
- **Lane independence:** lanes are independent. A stalled lane never blocks traffic addressed to another lane.

## Timing
- **Reset** (asynchronous, immediate on `rst`=1): every `x_valid`=0, `x_data`=0 and `x_cnt`=0. `in_ready` therefore reads 1 while `rst` is high.
- **Reset mid-operation:** words held in slots are discarded. No output handshake is counted during reset.
- **Latency:** accept in cycle N → `x_valid`=1 with the word in cycle N+1.
- **Throughput:** one word per cycle. This holds into a single lane when its ready is held high, and across lanes in any order.
- **Simultaneous drain and refill** on the same lane: the new word is loaded, valid stays 1, and the counter increments once.
- **Counter wrap:** `x_cnt`=2^CNT_W−1 plus one handshake gives 0 on the next edge.
- **Combinational paths:** there is no path from `in_valid` to `in_ready`. The `x_ready` → `in_ready` path exists only for the currently selected lane.

## Structure
- **Shared package `lane_pkg`:**
  - lane-select constants `SEL_A`=2'b01, `SEL_B`=2'b00, `SEL_C`=2'b10, `SEL_D`=2'b11
  - lane index enum
  
  The lane mux is updated to import the same package so that both ends share one mapping.
- **Sub-module `demux_lane_slot`:** one output register plus its counter. It has ports `clk`, `rst`, `load`, `load_data`, `out_data`, `out_valid`, `out_ready`, `free`, `cnt`. It is instantiated four times.
- **Top level:** contains only the select decode, the `in_ready` mux and the slot wiring.

## Test plan
- **Reset check:** assert `rst` mid-stream with lane b valid and stalled → all valids 0, data 0, counts 0 immediately; `in_ready`=1.
- **Lane routing and latency:** all readies high; send `in_data`=4'hA with `in_sel`=00, then 4'h5/01, 4'h3/10, 4'hC/11 on consecutive cycles. Each of `b_data`=A, `a_data`=5, `c_data`=3, `d_data`=C appears exactly one cycle after its accept with valid for one cycle. Each count = 1.
- **Backpressure isolation:** `a_ready`=0 and two words are sent to lane a. The first is accepted. The second sees `in_ready`=0 and is held, while a word sent to lane d meanwhile is accepted and delivered. Raising `a_ready` drains the first word and accepts the second in the same cycle.
- **Back-to-back into one lane:** `c_ready`=1 and 8 consecutive words 0..7 are sent to lane c → `in_ready` stays 1, `c_data` shows 0..7 on consecutive cycles, and `c_cnt`=8.
- **Counter wrap:** with CNT_W=8, deliver 257 words on lane d → `d_cnt`=1. The value is 255 after 255 words and 0 after 256.
- **Round trip:** connect to the 4-to-1 lane mux using the same registered `sel`; random words and selects → mux output equals the input word for every select.

Source files
------------

// File: rtl/lane_pkg.sv
// rtl/lane_pkg.sv - lane select mapping shared by the 1-to-4 demux and the 4-to-1 lane mux
package lane_pkg;

  // Select codes as seen on the wire; both ends of a link must agree on these
  localparam logic [1:0] SEL_A = 2'b01;
  localparam logic [1:0] SEL_B = 2'b00;
  localparam logic [1:0] SEL_C = 2'b10;
  localparam logic [1:0] SEL_D = 2'b11;

  // Physical lane index, used to address per-lane arrays
  typedef enum logic [1:0] {
    LANE_A = 2'd0,
    LANE_B = 2'd1,
    LANE_C = 2'd2,
    LANE_D = 2'd3
  } lane_e;

  function automatic lane_e sel_to_lane(input logic [1:0] sel);
    case (sel)
      SEL_A:   return LANE_A;
      SEL_B:   return LANE_B;
      SEL_C:   return LANE_C;
      default: return LANE_D;
    endcase
  endfunction

endpackage

// File: rtl/demux_lane_slot.sv
// rtl/demux_lane_slot.sv - one-entry output register with delivered-word counter
module demux_lane_slot #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [W-1:0]     load_data,
  output logic [W-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             free,
  output logic [CNT_W-1:0] cnt
);

  logic [W-1:0]     r_data;
  logic             r_valid;
  logic [CNT_W-1:0] r_cnt;
  logic             w_drain;

  assign w_drain   = r_valid & out_ready;
  // Free when empty or being drained this cycle, so a refill can overlap the drain
  assign free      = ~r_valid | out_ready;
  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign cnt       = r_cnt;

  // Slot contents: load wins over drain; data is left as-is on a plain drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (load) begin
      r_data  <= load_data;
      r_valid <= 1'b1;
    end else if (w_drain) begin
      r_valid <= 1'b0;
    end
  end

  // Delivered-word counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_drain) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/demux1to4_stream.sv
// rtl/demux1to4_stream.sv - registered 1-to-4 valid/ready stream demultiplexer
import lane_pkg::*;

module demux1to4_stream #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [W-1:0]     a_data,
  output logic [W-1:0]     b_data,
  output logic [W-1:0]     c_data,
  output logic [W-1:0]     d_data,
  output logic             a_valid,
  output logic             b_valid,
  output logic             c_valid,
  output logic             d_valid,
  input  logic             a_ready,
  input  logic             b_ready,
  input  logic             c_ready,
  input  logic             d_ready,
  output logic [CNT_W-1:0] a_cnt,
  output logic [CNT_W-1:0] b_cnt,
  output logic [CNT_W-1:0] c_cnt,
  output logic [CNT_W-1:0] d_cnt
);

  lane_e            w_lane;
  logic [3:0]       w_free;
  logic [3:0]       w_load;
  logic [3:0]       w_valid;
  logic [3:0]       w_ready;
  logic [W-1:0]     w_data [4];
  logic [CNT_W-1:0] w_cnt  [4];

  assign w_lane  = sel_to_lane(in_sel);
  // Only the selected lane's slot state reaches in_ready; in_valid never does
  assign in_ready = w_free[w_lane];
  assign w_ready  = {d_ready, c_ready, b_ready, a_ready};

  // One-hot load strobe toward the selected lane
  always_comb begin
    w_load         = '0;
    w_load[w_lane] = in_valid & in_ready;
  end

  for (genvar i = 0; i < 4; i++) begin : g_slot
    demux_lane_slot #(
      .W     (W),
      .CNT_W (CNT_W)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (w_load[i]),
      .load_data (in_data),
      .out_data  (w_data[i]),
      .out_valid (w_valid[i]),
      .out_ready (w_ready[i]),
      .free      (w_free[i]),
      .cnt       (w_cnt[i])
    );
  end

  assign a_data  = w_data[LANE_A];
  assign b_data  = w_data[LANE_B];
  assign c_data  = w_data[LANE_C];
  assign d_data  = w_data[LANE_D];
  assign a_valid = w_valid[LANE_A];
  assign b_valid = w_valid[LANE_B];
  assign c_valid = w_valid[LANE_C];
  assign d_valid = w_valid[LANE_D];
  assign a_cnt   = w_cnt[LANE_A];
  assign b_cnt   = w_cnt[LANE_B];
  assign c_cnt   = w_cnt[LANE_C];
  assign d_cnt   = w_cnt[LANE_D];

endmodule
